// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master: FSM states, CPU request
// codes and the request decoder.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    WAITLOW = 3'd4
  } state_t;

  localparam logic [7:0] WR0 = 8'h01;
  localparam logic [7:0] WR1 = 8'h02;
  localparam logic [7:0] RD0 = 8'h04;
  localparam logic [7:0] RD1 = 8'h05;

  typedef struct packed {
    logic legal;
    logic write;
    logic slot;
  } dec_t;

  // Map a CPU request code onto {legal, direction, target slot}.
  function automatic dec_t decode(input logic [7:0] code);
    dec_t d;
    d = '0;
    case (code)
      WR0: begin d.legal = 1'b1; d.write = 1'b1; d.slot = 1'b0; end
      WR1: begin d.legal = 1'b1; d.write = 1'b1; d.slot = 1'b1; end
      RD0: begin d.legal = 1'b1; d.write = 1'b0; d.slot = 1'b0; end
      RD1: begin d.legal = 1'b1; d.write = 1'b0; d.slot = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB3 master: turns one CPU request (rising edge of APBMASTERENABLE) into
// exactly one APB transfer, returns CPUPREADY/RDATA, and pulses INCPURESET
// on an illegal code, a slave error or an ACCESS timeout.
//
// CPU handshake: APBMASTERENABLE is a level request held by the CPU until it
// sees CPUPREADY. A transfer launches only on the rising edge of the request;
// CPUPREADY stays high until the request drops. After an error the master
// waits for the request to drop before it will accept another one.
module apb_master
  import apb_pkg::*;
#(
  parameter int PDATA_W = 32,
  parameter int NSLAVE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               CCLK,
  input  logic               CPURESETN,
  input  logic               APBMASTERENABLE,
  input  logic [7:0]         CPUSEL,
  input  logic [7:0]         addr,
  input  logic [20:0]        data,
  output logic               CPUPREADY,
  output logic [PDATA_W-1:0] RDATA,
  output logic               INCPURESET,
  output logic [NSLAVE-1:0]  PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [7:0]         PADDR,
  output logic [PDATA_W-1:0] PWDATA,
  input  logic [PDATA_W-1:0] PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t     state_q;
  logic       en_q;
  logic [CNT_W-1:0] cnt_q;
  dec_t       dec;

  // Decode the request code combinationally; only used at launch.
  assign dec     = decode(CPUSEL);
  assign state_o = state_q;

  // Transfer FSM with registered APB/CPU outputs and the wait-state counter.
  always_ff @(posedge CCLK) begin
    if (!CPURESETN) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      CPUPREADY  <= 1'b0;
      RDATA      <= '0;
      INCPURESET <= 1'b0;
      PSEL       <= '0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else begin
      en_q       <= APBMASTERENABLE;
      INCPURESET <= 1'b0;
      case (state_q)
        IDLE: begin
          if (APBMASTERENABLE && !en_q) begin
            if (dec.legal) begin
              PADDR   <= addr;
              PWDATA  <= PDATA_W'(data);
              PWRITE  <= dec.write;
              PSEL    <= NSLAVE'(1) << dec.slot;
              cnt_q   <= '0;
              state_q <= SETUP;
            end else begin
              INCPURESET <= 1'b1;
              state_q    <= WAITLOW;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              INCPURESET <= 1'b1;
              state_q    <= WAITLOW;
            end else begin
              if (!PWRITE) RDATA <= PRDATA;
              CPUPREADY <= 1'b1;
              state_q   <= DONE;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th wait cycle: abandon the transfer.
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            INCPURESET <= 1'b1;
            state_q    <= WAITLOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (!APBMASTERENABLE) begin
            CPUPREADY <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WAITLOW: begin
          if (!APBMASTERENABLE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4 so the timeout path is short).
module tb_apb_master;

  logic        CCLK = 1'b0;
  logic        CPURESETN = 1'b0;
  logic        APBMASTERENABLE = 1'b0;
  logic [7:0]  CPUSEL = 8'h00;
  logic [7:0]  addr = 8'h00;
  logic [20:0] data = '0;
  logic        CPUPREADY;
  logic [31:0] RDATA;
  logic        INCPURESET;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_master #(.PDATA_W(32), .NSLAVE(2), .TIMEOUT(4)) dut (
    .CCLK(CCLK), .CPURESETN(CPURESETN), .APBMASTERENABLE(APBMASTERENABLE),
    .CPUSEL(CPUSEL), .addr(addr), .data(data), .CPUPREADY(CPUPREADY),
    .RDATA(RDATA), .INCPURESET(INCPURESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .state_o(state_o)
  );

  // Clock
  always #5 CCLK = ~CCLK;

  // Protocol invariants sampled on the falling edge.
  always @(negedge CCLK) begin
    if (CPURESETN) begin
      n_cmp++;
      if (((PSEL & (PSEL - 2'd1)) != 2'd0) || (PENABLE && PSEL == 2'd0)) begin
        n_err++;
        $display("FAIL protocol: PSEL=%b PENABLE=%b (one-hot PSEL, PENABLE only with PSEL)", PSEL, PENABLE);
      end
    end
  end

  task automatic tick;
    @(posedge CCLK);
    #1;
  endtask

  task automatic test_reset;
    CPURESETN = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, RDATA, CPUPREADY, INCPURESET} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: PSEL=%b PEN=%b PWR=%b PADDR=%h PWDATA=%h RDATA=%h RDY=%b INC=%b, want all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, RDATA, CPUPREADY, INCPURESET);
    end
    n_cmp++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    CPURESETN = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait;
    PREADY = 1'b1; PSLVERR = 1'b0;
    CPUSEL = 8'h01; addr = 8'h3C; data = 21'h1ABCD; APBMASTERENABLE = 1'b1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, CPUPREADY} !== {2'b01, 1'b0, 1'b1, 8'h3C, 32'h0001ABCD, 1'b0}) begin
      n_err++;
      $display("FAIL wr_setup: PSEL=%b PEN=%b PWR=%b PADDR=%h PWDATA=%h RDY=%b want 01 0 1 3c 0001abcd 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, CPUPREADY);
    end
    // Inputs changing after launch must not affect the transfer.
    CPUSEL = 8'h05; addr = 8'hFF; data = 21'h0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PADDR, PWDATA, CPUPREADY} !== {2'b01, 1'b1, 8'h3C, 32'h0001ABCD, 1'b0}) begin
      n_err++;
      $display("FAIL wr_access: PSEL=%b PEN=%b PADDR=%h PWDATA=%h RDY=%b want 01 1 3c 0001abcd 0",
               PSEL, PENABLE, PADDR, PWDATA, CPUPREADY);
    end
    tick();
    n_cmp++;
    if ({CPUPREADY, PSEL, PENABLE} !== {1'b1, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL wr_done: RDY=%b PSEL=%b PEN=%b want 1 00 0", CPUPREADY, PSEL, PENABLE);
    end
    tick(); tick();
    n_cmp++;
    if (CPUPREADY !== 1'b1) begin n_err++; $display("FAIL wr_hold: RDY=%b want 1", CPUPREADY); end
    APBMASTERENABLE = 1'b0;
    tick();
    n_cmp++;
    if ({CPUPREADY, state_o} !== {1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL wr_release: RDY=%b state=%0d want 0 0", CPUPREADY, state_o);
    end
  endtask

  task automatic test_read_waits;
    PREADY = 1'b0; PRDATA = 32'hDEADBEEF;
    CPUSEL = 8'h05; addr = 8'h10; APBMASTERENABLE = 1'b1;
    tick();
    n_cmp++;
    if ({PSEL, PWRITE, PENABLE} !== {2'b10, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rd_setup: PSEL=%b PWR=%b PEN=%b want 10 0 0", PSEL, PWRITE, PENABLE);
    end
    tick(); tick(); tick();
    n_cmp++;
    if ({PSEL, PENABLE, CPUPREADY} !== {2'b10, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rd_wait: PSEL=%b PEN=%b RDY=%b want 10 1 0", PSEL, PENABLE, CPUPREADY);
    end
    PREADY = 1'b1;
    tick();
    n_cmp++;
    if ({CPUPREADY, RDATA, PSEL} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
      n_err++;
      $display("FAIL rd_done: RDY=%b RDATA=%h PSEL=%b want 1 deadbeef 00", CPUPREADY, RDATA, PSEL);
    end
    APBMASTERENABLE = 1'b0;
    tick();
  endtask

  task automatic test_slave_error;
    int bad;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h12345678;
    CPUSEL = 8'h02; APBMASTERENABLE = 1'b1;
    tick();
    n_cmp++;
    if ({PSEL, PWRITE} !== {2'b10, 1'b1}) begin
      n_err++;
      $display("FAIL err_setup: PSEL=%b PWR=%b want 10 1", PSEL, PWRITE);
    end
    tick(); tick();
    n_cmp++;
    if ({INCPURESET, CPUPREADY, PSEL, PENABLE, RDATA} !== {1'b1, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL err_pulse: INC=%b RDY=%b PSEL=%b PEN=%b RDATA=%h want 1 0 00 0 deadbeef",
               INCPURESET, CPUPREADY, PSEL, PENABLE, RDATA);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (INCPURESET !== 1'b0 || CPUPREADY !== 1'b0 || PSEL !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL err_quiet: %0d active cycles want 0", bad); end
    n_cmp++;
    if (state_o !== 3'd4) begin n_err++; $display("FAIL err_waitlow: state=%0d want 4", state_o); end
    APBMASTERENABLE = 1'b0; PSLVERR = 1'b0;
    tick();
    n_cmp++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL err_idle: state=%0d want 0", state_o); end
  endtask

  task automatic test_timeout;
    PREADY = 1'b0; CPUSEL = 8'h01; APBMASTERENABLE = 1'b1;
    tick();         // SETUP
    tick();         // ACCESS cycle 1
    tick(); tick(); tick();  // ACCESS cycles 2..4
    n_cmp++;
    if ({PSEL, PENABLE, INCPURESET} !== {2'b01, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL to_access4: PSEL=%b PEN=%b INC=%b want 01 1 0", PSEL, PENABLE, INCPURESET);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, INCPURESET, CPUPREADY} !== {2'b00, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL to_abort: PSEL=%b PEN=%b INC=%b RDY=%b want 00 0 1 0", PSEL, PENABLE, INCPURESET, CPUPREADY);
    end
    tick();
    n_cmp++;
    if (INCPURESET !== 1'b0) begin n_err++; $display("FAIL to_pulse_len: INC=%b want 0", INCPURESET); end
    APBMASTERENABLE = 1'b0;
    tick();
  endtask

  task automatic test_illegal;
    CPUSEL = 8'h03; APBMASTERENABLE = 1'b1;
    tick();
    n_cmp++;
    if ({INCPURESET, PSEL, state_o} !== {1'b1, 2'b00, 3'd4}) begin
      n_err++;
      $display("FAIL ill_pulse: INC=%b PSEL=%b state=%0d want 1 00 4", INCPURESET, PSEL, state_o);
    end
    tick();
    n_cmp++;
    if ({INCPURESET, PSEL} !== {1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL ill_after: INC=%b PSEL=%b want 0 00", INCPURESET, PSEL);
    end
    APBMASTERENABLE = 1'b0;
    tick();
  endtask

  task automatic test_held_level;
    int setups;
    int sel_cycles;
    setups = 0; sel_cycles = 0;
    PREADY = 1'b1; CPUSEL = 8'h04; APBMASTERENABLE = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (state_o === 3'd1) setups++;
      if (PSEL !== 2'b00) sel_cycles++;
    end
    n_cmp++;
    if (setups !== 1) begin n_err++; $display("FAIL held_setups: got %0d want 1", setups); end
    n_cmp++;
    if (sel_cycles !== 2) begin n_err++; $display("FAIL held_psel: got %0d want 2", sel_cycles); end
    n_cmp++;
    if (CPUPREADY !== 1'b1) begin n_err++; $display("FAIL held_ready: RDY=%b want 1", CPUPREADY); end
    APBMASTERENABLE = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    PREADY = 1'b0; CPUSEL = 8'h04; APBMASTERENABLE = 1'b1;
    tick(); tick();
    n_cmp++;
    if (state_o !== 3'd2) begin n_err++; $display("FAIL mid_in_access: state=%0d want 2", state_o); end
    CPURESETN = 1'b0; APBMASTERENABLE = 1'b0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, RDATA, CPUPREADY, INCPURESET, state_o} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: PSEL=%b PEN=%b RDATA=%h RDY=%b INC=%b state=%0d want all 0",
               PSEL, PENABLE, RDATA, CPUPREADY, INCPURESET, state_o);
    end
    CPURESETN = 1'b1;
    tick();
    PREADY = 1'b1; CPUSEL = 8'h02; addr = 8'hA5; data = 21'h1FFFFF; APBMASTERENABLE = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({CPUPREADY, PADDR, PWDATA} !== {1'b1, 8'hA5, 32'h001FFFFF}) begin
      n_err++;
      $display("FAIL mid_fresh: RDY=%b PADDR=%h PWDATA=%h want 1 a5 001fffff", CPUPREADY, PADDR, PWDATA);
    end
    APBMASTERENABLE = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_timeout();
    test_illegal();
    test_held_level();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
